// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM state
// constants and the size of the attached word memory.
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Attached memory depth in 32-bit words; byte addresses beyond it are rejected
    localparam int MEM_WORDS       = 1024;
    localparam int ADDR_LIMIT_BITS = $clog2(MEM_WORDS * 4);

    // FSM state type and encodings
    typedef logic [2:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE    = 3'd0;
    localparam lsu_state_t ST_RD_ADDR = 3'd1;
    localparam lsu_state_t ST_RD_DATA = 3'd2;
    localparam lsu_state_t ST_WR      = 3'd3;
    localparam lsu_state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction for loads and lane merge for sub-word stores.
// Purely combinational. Sub-word handling exists only when LSU_SUBWORD_EN is
// defined; otherwise words pass straight through and no merge logic is built.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] rdata_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

`ifdef LSU_SUBWORD_EN
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lanes out of the memory word, extend them, and build
    // the read-modify-write word with only the addressed lanes replaced
    always_comb begin
        sel_byte    = rdata_word[{lane, 3'b000} +: 8];
        sel_half    = rdata_word[{lane[1], 4'b0000} +: 16];
        load_data   = rdata_word;
        merged_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data   = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
                merged_word = rdata_word;
                merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data   = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
                merged_word = rdata_word;
                merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end
`else
    // Word-only build: size/lane/sign controls have no effect
    logic unused_ok;
    assign unused_ok   = ^{size, lane, is_unsigned};
    assign load_data   = rdata_word;
    assign merged_word = wdata;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, performs it against a
// word-addressed synchronous memory and returns a one-cycle response pulse.
// Build option: define LSU_SUBWORD_EN to enable byte/half accesses (sub-word
// stores use read-modify-write); without it only aligned words are legal.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rw,
    output logic [31:0] mem_ain,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    lsu_state_t  state;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Classify the incoming request: out-of-range, misaligned or unsupported size
    always_comb begin
        req_err = (req_addr[31:ADDR_LIMIT_BITS] != '0);
`ifdef LSU_SUBWORD_EN
        case (req_size)
            SZ_BYTE: ;
            SZ_HALF: if (req_addr[0]) req_err = 1'b1;
            SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
`else
        if (req_size != SZ_WORD || req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

    lsu_align u_align (
        .size        (size_reg),
        .lane        (addr_reg[1:0]),
        .is_unsigned (uns_reg),
        .rdata_word  (mem_dout),
        .wdata       (wdata_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Request capture and sequencing through the access FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            we_reg    <= 1'b0;
            size_reg  <= SZ_BYTE;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg    <= req_we;
                        size_reg  <= req_size;
                        uns_reg   <= req_unsigned;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        rdata_reg <= '0;
                        err_reg   <= req_err;
                        if (req_err)
                            state <= ST_RESP;
                        else if (req_we && req_size == SZ_WORD)
                            state <= ST_WR;
                        else
                            state <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    if (we_reg) begin
                        wdata_reg <= merged_word;
                        state     <= ST_WR;
                    end else begin
                        rdata_reg <= load_data;
                        state     <= ST_RESP;
                    end
                end
                ST_WR:   state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state so reset clears them without waiting for an edge
    always_comb begin
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_reg;
        resp_rdata = (state == ST_RESP) ? rdata_reg : 32'h0;
        mem_rw     = (state == ST_WR);
        mem_ain    = (state != ST_IDLE) ? {2'b00, addr_reg[31:2]} : 32'h0;
        mem_din    = (state == ST_WR) ? wdata_reg : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random
// requests, all compared against a byte-level reference memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rw;
    logic [31:0] mem_ain;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    logic [31:0] mem     [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    int wr_count = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_rw       (mem_rw),
        .mem_ain      (mem_ain),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    // Synchronous word memory: write when mem_rw, otherwise read into mem_dout
    always @(posedge clock) begin
        if (mem_rw) begin
            mem[mem_ain[9:0]] <= mem_din;
            wr_count = wr_count + 1;
        end else begin
            mem_dout <= mem[mem_ain[9:0]];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: legality, result, latency to response, and write count
    function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wd,
                                  output bit err, output bit [31:0] rd,
                                  output int lat, output int writes);
        int nbytes, lane, idx;
        bit [31:0] mask, word, val;
        bit subword_ok;
`ifdef LSU_SUBWORD_EN
        subword_ok = 1'b1;
`else
        subword_ok = 1'b0;
`endif
        nbytes = 1 << sz;
        err = (sz == 2'd3) || (addr >= 32'h1000) || ((addr % nbytes) != 0) ||
              (!subword_ok && sz != 2'd2);
        rd = 32'h0;
        writes = 0;
        if (err) begin
            lat = 1;
            return;
        end
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        lane = int'(addr % 4);
        idx  = int'(addr / 4);
        word = ref_mem[idx];
        if (!we) begin
            val = (word >> (8 * lane)) & mask;
            if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
            rd  = val;
            lat = 3;
        end else begin
            ref_mem[idx] = (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
            lat    = (nbytes == 4) ? 2 : 4;
            writes = 1;
        end
    endfunction

    // One request: drive, scramble inputs after acceptance, check response
    task automatic run_op(input string tag, input bit we, input bit [1:0] sz, input bit uns,
                          input bit [31:0] addr, input bit [31:0] wd);
        bit e_err;
        bit [31:0] e_rd;
        int e_lat, e_wr, lat, w0;
        model(we, sz, uns, addr, wd, e_err, e_rd, e_lat, e_wr);
        @(negedge clock);
        w0 = wr_count;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
        req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".err"}, {31'h0, resp_err}, {31'h0, e_err});
        chk({tag, ".rdata"}, resp_rdata, e_rd);
        chk({tag, ".ready_in_resp"}, {31'h0, req_ready}, 32'h0);
        @(posedge clock); #1;
        chk({tag, ".pulse_end"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, ".ready_after"}, {31'h0, req_ready}, 32'h1);
        chk({tag, ".writes"}, wr_count - w0, e_wr);
        $display("txn %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
                 tag, we, sz, uns, addr, wd, resp_err, resp_rdata, lat);
    endtask

    initial begin
        int w0;
        bit rwe, runs;
        bit [1:0] rsz;
        bit [31:0] raddr;
        int pick;

        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        chk("reset.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset.mem_rw", {31'h0, mem_rw}, 32'h0);
        chk("reset.mem_ain", mem_ain, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("reset.ready_first", {31'h0, req_ready}, 32'h1);

        // Word store then word load of the same location
        run_op("word_store_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("word_store_10.mem4", mem[4], 32'hDEADBEEF);
        run_op("word_load_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Byte store into lane 1 and byte loads of the top lane
        run_op("byte_store_11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
`ifdef LSU_SUBWORD_EN
        chk("byte_store_11.mem4", mem[4], 32'hDEAD55EF);
`else
        chk("byte_store_11.mem4", mem[4], 32'hDEADBEEF);
`endif
        run_op("byte_load_13_s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        run_op("byte_load_13_u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

        // Half loads: aligned upper half, then misaligned
        run_op("word_store_8001", 1'b1, 2'd2, 1'b0, 32'h10, 32'h80011234);
        run_op("half_load_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        run_op("half_load_11", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);

        // Out-of-range and illegal size
        run_op("word_load_1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        run_op("size3_load", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        run_op("byte_store_20", 1'b1, 2'd0, 1'b0, 32'h20, 32'hA5);

        // Reset asserted while the write is being presented to memory
        run_op("word_store_40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h13579BDF);
        @(negedge clock);
        w0 = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rst_wr.in_wr", {31'h0, mem_rw}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_wr.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_wr.resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_wr.resp_rdata", resp_rdata, 32'h0);
        chk("rst_wr.mem_rw", {31'h0, mem_rw}, 32'h0);
        chk("rst_wr.mem_ain", mem_ain, 32'h0);
        chk("rst_wr.mem_din", mem_din, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_wr.ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_wr.no_resp", {31'h0, resp_valid}, 32'h0);
        end
        chk("rst_wr.writes", wr_count - w0, 0);
        chk("rst_wr.mem16", mem[16], 32'h13579BDF);
        $display("txn rst_wr mem16=%h writes=%0d", mem[16], wr_count - w0);

        // Random requests over a small window so stores and loads overlap
        for (int n = 0; n < 80; n++) begin
            pick = int'($urandom_range(0, 7));
            rsz  = (pick < 2) ? 2'd0 : (pick < 4) ? 2'd1 : (pick < 7) ? 2'd2 : 2'd3;
            rwe  = 1'($urandom);
            runs = 1'($urandom);
            raddr = ($urandom_range(0, 11) == 0) ? (32'h1000 + $urandom_range(0, 63))
                                                 : 32'($urandom_range(0, 63));
            run_op("rnd", rwe, rsz, runs, raddr, $urandom);
        end

        for (int i = 0; i < 16; i++) begin
            chk("final.mem", mem[i], ref_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
